// File: rtl/ps2_event_rx_if.sv
// Decoded key-event handshake between the PS/2 receiver (master) and its consumer (slave).
interface ps2_event_rx_if;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;

    modport master (output evt_code, evt_ext, evt_break, evt_valid, input evt_ready);
    modport slave  (input evt_code, evt_ext, evt_break, evt_valid, output evt_ready);
endinterface

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: synchronises the line pair, checks 11-bit frames, folds
// E0/F0 prefixes into flags and buffers key events in a small valid/ready FIFO.
module ps2_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           res,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_event_rx_if.master evt,
    output logic           frame_err,
    output logic           overflow,
    input  logic           ovf_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_data;

    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_data = r_data_sync[SYNC_STAGES-1];

    logic [1:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_byte;
    logic             r_parity;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_accept;
    logic             r_frame_err;

    // r_accept is high in the cycle after the stop-bit edge, with r_byte holding the frame.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_byte      <= '0;
            r_parity    <= 1'b0;
            r_idle_cnt  <= '0;
            r_accept    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_accept    <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state != ST_IDLE && !w_fall && r_idle_cnt == CNT_W'(TIMEOUT_CYC)) begin
                r_state     <= ST_IDLE;
                r_idle_cnt  <= '0;
                r_frame_err <= 1'b1;
            end else begin
                if (r_state == ST_IDLE || w_fall) r_idle_cnt <= '0;
                else                              r_idle_cnt <= r_idle_cnt + 1'b1;
                if (w_fall) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (!w_data) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                        ST_DATA: begin
                            r_byte    <= {w_data, r_byte[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                        end
                        ST_PARITY: begin
                            r_parity <= w_data;
                            r_state  <= ST_STOP;
                        end
                        default: begin
                            if (w_data && ((^r_byte) ^ r_parity)) r_accept    <= 1'b1;
                            else                                   r_frame_err <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign frame_err = r_frame_err;

    logic r_ext_pend;
    logic r_brk_pend;
    logic w_push;

    assign w_push = r_accept && (r_byte != 8'hE0) && (r_byte != 8'hF0);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_frame_err || w_push) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_accept) begin
            if (r_byte == 8'hE0) r_ext_pend <= 1'b1;
            if (r_byte == 8'hF0) r_brk_pend <= 1'b1;
        end
    end

    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             w_valid;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic [9:0]       w_head;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & evt.evt_ready;
    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_wr    = w_push & (~w_full | w_pop);

    // NOTE: the storage array has no reset; only pointers and count define
    // occupancy, and the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_byte, r_ext_pend, r_brk_pend};
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) r_overflow <= 1'b1;
            else if (ovf_clr)    r_overflow <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign evt.evt_valid = w_valid;
    assign evt.evt_code  = w_valid ? w_head[9:2] : 8'h00;
    assign evt.evt_ext   = w_valid & w_head[1];
    assign evt.evt_break = w_valid & w_head[0];
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_ps2_event_rx.sv
// Directed bench for ps2_event_rx: an event-level model of prefix folding and FIFO
// occupancy, a per-cycle compare process, and hand-computed timing/value expectations.
module tb_ps2_event_rx;
    localparam int SYNC  = 2;
    localparam int TMO   = 300;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    logic clk      = 1'b0;
    logic res      = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic ovf_clr  = 1'b0;
    logic frame_err;
    logic overflow;

    ps2_event_rx_if evt ();

    always #5 clk = ~clk;

    ps2_event_rx #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .res       (res),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt       (evt),
        .frame_err (frame_err),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event-level model: what the consumer must eventually see.
    evt_t mdl_q[$];
    logic mdl_ext = 1'b0;
    logic mdl_brk = 1'b0;
    logic mdl_ovf = 1'b0;
    int   mdl_err = 0;

    function automatic void mdl_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            mdl_err++;
            mdl_ext = 1'b0;
            mdl_brk = 1'b0;
        end else if (b == 8'hE0) begin
            mdl_ext = 1'b1;
        end else if (b == 8'hF0) begin
            mdl_brk = 1'b1;
        end else begin
            if (mdl_q.size() < DEPTH) mdl_q.push_back('{code: b, ext: mdl_ext, brk: mdl_brk});
            else                      mdl_ovf = 1'b1;
            mdl_ext = 1'b0;
            mdl_brk = 1'b0;
        end
    endfunction

    int   cyc      = 0;
    int   fall_cyc = 0;
    int   err_seen = 0;
    int   err_cyc  = -1;
    int   rise_cyc = -1;
    logic prev_err = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_hold  = 1'b0;
    evt_t prev_evt;
    evt_t popped[$];

    always @(posedge clk) cyc++;

    // Compare process: sampled on the falling clock edge.
    always @(negedge clk) begin
        evt_t cur;
        cur = '{code: evt.evt_code, ext: evt.evt_ext, brk: evt.evt_break};
        if (!res) begin
            prev_err   = 1'b0;
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (frame_err) begin
                err_seen++;
                err_cyc = cyc;
                check("frame_err_single_cycle", prev_err, 1'b0);
            end
            if (evt.evt_valid && !prev_valid) rise_cyc = cyc;
            if (prev_hold && evt.evt_valid) check("evt_stable_while_stalled", cur, prev_evt);
            if (evt.evt_valid && evt.evt_ready) begin
                if (mdl_q.size() == 0) begin
                    check("pop_unexpected", evt.evt_valid, 1'b0);
                end else begin
                    check("pop_evt", cur, mdl_q[0]);
                    popped.push_back(cur);
                    void'(mdl_q.pop_front());
                end
            end
            prev_err   = frame_err;
            prev_valid = evt.evt_valid;
            prev_hold  = evt.evt_valid & ~evt.evt_ready;
            prev_evt   = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            tick(HALF);
            ps2_clk  = 1'b1;
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits(make_frame(b, bad_par), 11);
        tick(HALF);
        mdl_byte(b, !bad_par);
    endtask

    task automatic drain();
        int n;
        n = 0;
        evt.evt_ready = 1'b1;
        while (mdl_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        evt.evt_ready = 1'b0;
        tick(1);
        check("drain_model_empty", mdl_q.size(), 0);
        check("drain_valid_low", evt.evt_valid, 1'b0);
    endtask

    initial begin
        int e0;
        int n;
        evt.evt_ready = 1'b0;
        tick(5);
        check("reset_valid", evt.evt_valid, 1'b0);
        check("reset_code", evt.evt_code, 8'h00);
        check("reset_ext", evt.evt_ext, 1'b0);
        check("reset_break", evt.evt_break, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        res = 1'b1;
        tick(5);

        // Plain make code; stop-bit pin fall -> evt_valid four clock edges later (T+2).
        send_byte(8'h1C, 1'b0);
        check("make_latency", rise_cyc - fall_cyc, 4);
        check("make_valid", evt.evt_valid, 1'b1);
        check("make_code", evt.evt_code, 8'h1C);
        check("make_ext", evt.evt_ext, 1'b0);
        check("make_break", evt.evt_break, 1'b0);
        check("model_make", mdl_q[0], {8'h1C, 1'b0, 1'b0});
        evt.evt_ready = 1'b1;
        tick(1);
        check("make_pop_valid_low", evt.evt_valid, 1'b0);
        evt.evt_ready = 1'b0;

        // Extended break: prefixes alone emit nothing.
        send_byte(8'hE0, 1'b0);
        check("e0_no_event", evt.evt_valid, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("f0_no_event", evt.evt_valid, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_brk_code", evt.evt_code, 8'h75);
        check("ext_brk_ext", evt.evt_ext, 1'b1);
        check("ext_brk_break", evt.evt_break, 1'b1);
        check("ext_brk_count", mdl_q.size(), 1);
        drain();

        // Parity error, then a clean break event.
        e0 = err_seen;
        send_byte(8'h1C, 1'b1);
        check("parity_err_count", err_seen, e0 + 1);
        check("parity_err_latency", err_cyc - fall_cyc, 3);
        check("parity_no_event", evt.evt_valid, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("after_err_code", evt.evt_code, 8'h1C);
        check("after_err_break", evt.evt_break, 1'b1);
        check("after_err_ext", evt.evt_ext, 1'b0);
        drain();

        // Timeout on a partial frame (start + 4 bits).
        e0 = err_seen;
        send_bits(make_frame(8'h29, 1'b0), 5);
        n = 0;
        while (err_seen == e0 && n < TMO + 100) begin
            tick(1);
            n++;
        end
        mdl_byte(8'h00, 1'b0);
        check("timeout_err_count", err_seen, e0 + 1);
        check("timeout_latency", err_cyc - fall_cyc, TMO + 4);
        tick(HALF);
        send_byte(8'h29, 1'b0);
        check("after_timeout_code", evt.evt_code, 8'h29);
        check("after_timeout_flags", {evt.evt_ext, evt.evt_break}, 2'b00);
        drain();

        // Overflow: five make codes into a four-entry FIFO.
        popped.delete();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("model_ovf", mdl_ovf, 1'b1);
        check("ovf_model_depth", mdl_q.size(), DEPTH);
        drain();
        check("ovf_popped_count", popped.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < popped.size(); k++)
            check($sformatf("ovf_order_%0d", k), popped[k].code, 8'(k + 1));
        check("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Reset mid-frame with two events buffered.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("pre_reset_valid", evt.evt_valid, 1'b1);
        send_bits(make_frame(8'h33, 1'b0), 3);
        res = 1'b0;
        #1;
        check("reset_async_valid", evt.evt_valid, 1'b0);
        check("reset_async_code", evt.evt_code, 8'h00);
        mdl_q.delete();
        mdl_ext = 1'b0;
        mdl_brk = 1'b0;
        tick(3);
        res = 1'b1;
        tick(5);
        send_byte(8'h16, 1'b0);
        check("post_reset_code", evt.evt_code, 8'h16);
        check("post_reset_flags", {evt.evt_ext, evt.evt_break}, 2'b00);
        check("post_reset_count", mdl_q.size(), 1);
        drain();

        check("err_total", err_seen, mdl_err);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
